// File: rtl/sobel_px_feeder.sv
// Frame-memory reader feeding a Sobel 3x3 window controller: column-major
// pixel order, strip by strip, 9 pixels for a strip's first window then 3 per window.
module sobel_px_feeder #(
  parameter int PIXEL_WIDTH_OUT = 8,
  parameter int IMG_WIDTH       = 16,
  parameter int IMG_HEIGHT      = 16,
  parameter int ADDR_BITS       = 8,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       start_i,
  input  logic                       hold_i,
  output logic                       rd_en_o,
  output logic [ADDR_BITS-1:0]       rd_addr_o,
  input  logic [PIXEL_WIDTH_OUT-1:0] rd_data_i,
  output logic [PIXEL_WIDTH_OUT-1:0] px_o,
  output logic                       px_rdy_o,
  output logic                       start_sobel_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int COL_BITS   = $clog2(IMG_WIDTH);
  localparam int STRIP_BITS = $clog2(IMG_HEIGHT);
  localparam int GAP_BITS   = $clog2(GAP_CYCLES + 1);

  localparam logic [COL_BITS-1:0]   LAST_COL   = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [COL_BITS-1:0]   FILL_COL   = COL_BITS'(2);
  localparam logic [STRIP_BITS-1:0] LAST_STRIP = STRIP_BITS'(IMG_HEIGHT - 3);
  localparam logic [GAP_BITS-1:0]   LAST_GAP   = GAP_BITS'(GAP_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0]  ROW_STEP   = ADDR_BITS'(IMG_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SLIDE,
    S_DRAIN,
    S_GAP,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [COL_BITS-1:0]    col_q;
  logic [1:0]             row_in_q;
  logic [ADDR_BITS-1:0]   row_off_q;
  logic [ADDR_BITS-1:0]   row_base_q;
  logic [STRIP_BITS-1:0]  strip_q;
  logic [GAP_BITS-1:0]    gap_q;
  logic                   rd_pend_q;
  logic                   strip_act_q;
  logic [PIXEL_WIDTH_OUT-1:0] px_q;
  logic                   px_rdy_q;

  logic issue;
  logic col_end;
  logic last_read;
  logic fill_end;
  logic strip_end;

  assign issue     = ((state_q == S_FILL) || (state_q == S_SLIDE)) && !hold_i;
  assign col_end   = (row_in_q == 2'd2);
  assign last_read = issue && col_end && (col_q == LAST_COL);
  assign fill_end  = issue && col_end && (col_q == FILL_COL);
  // The strip is finished once the final pixel is on px_o and no read is still in flight.
  assign strip_end = (state_q == S_DRAIN) && px_rdy_q && !rd_pend_q;

  // NOTE: state_d gets its default first so every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_FILL;
      S_FILL: begin
        if (last_read)     state_d = S_DRAIN;
        else if (fill_end) state_d = S_SLIDE;
      end
      S_SLIDE: if (last_read) state_d = S_DRAIN;
      S_DRAIN: if (strip_end) state_d = (strip_q == LAST_STRIP) ? S_DONE : S_GAP;
      S_GAP:   if (gap_q == LAST_GAP) state_d = S_FILL;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address counters: row offset and row base advance by IMG_WIDTH steps, so only adders are needed.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col_q      <= '0;
      row_in_q   <= '0;
      row_off_q  <= '0;
      row_base_q <= '0;
      strip_q    <= '0;
      gap_q      <= '0;
    end else if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
      col_q      <= '0;
      row_in_q   <= '0;
      row_off_q  <= '0;
      row_base_q <= '0;
      strip_q    <= '0;
      gap_q      <= '0;
    end else if (issue) begin
      if (col_end) begin
        row_in_q  <= '0;
        row_off_q <= '0;
        col_q     <= (col_q == LAST_COL) ? '0 : col_q + COL_BITS'(1);
      end else begin
        row_in_q  <= row_in_q + 2'd1;
        row_off_q <= row_off_q + ROW_STEP;
      end
    end else if (state_q == S_GAP) begin
      if (gap_q == LAST_GAP) begin
        gap_q      <= '0;
        strip_q    <= strip_q + STRIP_BITS'(1);
        row_base_q <= row_base_q + ROW_STEP;
      end else begin
        gap_q <= gap_q + GAP_BITS'(1);
      end
    end
  end

  // Two-stage read pipe: data arrives one cycle after the strobe and is registered onto px_o.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      rd_pend_q   <= 1'b0;
      px_rdy_q    <= 1'b0;
      px_q        <= '0;
      strip_act_q <= 1'b0;
    end else begin
      rd_pend_q <= issue;
      px_rdy_q  <= rd_pend_q;
      if (rd_pend_q) px_q <= rd_data_i;
      if (strip_end)  strip_act_q <= 1'b0;
      else if (issue) strip_act_q <= 1'b1;
    end
  end

  assign rd_en_o       = issue;
  assign rd_addr_o     = row_base_q + row_off_q + ADDR_BITS'(col_q);
  assign px_o          = px_q;
  assign px_rdy_o      = px_rdy_q;
  assign start_sobel_o = strip_act_q | issue;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_sobel_px_feeder.sv
// Bench for sobel_px_feeder: a 4x4 and a default 16x16 instance, each checked against
// a window-order model built from the frame geometry, with directed and random hold/data.
module tb_sobel_px_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset;
  logic start, hold, sel;

  logic       start4, hold4, rd_en4, px_rdy4, ss4, busy4, done4;
  logic [3:0] rd_addr4;
  logic [7:0] rd_data4, px4;
  logic       start16, hold16, rd_en16, px_rdy16, ss16, busy16, done16;
  logic [7:0] rd_addr16, rd_data16, px16;

  logic [7:0] mem [256];

  assign start4  = !sel & start;
  assign hold4   = !sel & hold;
  assign start16 = sel & start;
  assign hold16  = sel & hold;

  sobel_px_feeder #(.PIXEL_WIDTH_OUT(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .ADDR_BITS(4), .GAP_CYCLES(2)) dut4 (
    .clk_i(clk), .nreset_i(nreset), .start_i(start4), .hold_i(hold4),
    .rd_en_o(rd_en4), .rd_addr_o(rd_addr4), .rd_data_i(rd_data4),
    .px_o(px4), .px_rdy_o(px_rdy4), .start_sobel_o(ss4), .busy_o(busy4), .done_o(done4)
  );

  sobel_px_feeder dut16 (
    .clk_i(clk), .nreset_i(nreset), .start_i(start16), .hold_i(hold16),
    .rd_en_o(rd_en16), .rd_addr_o(rd_addr16), .rd_data_i(rd_data16),
    .px_o(px16), .px_rdy_o(px_rdy16), .start_sobel_o(ss16), .busy_o(busy16), .done_o(done16)
  );

  // Synchronous-read frame memories, one read port per instance.
  always @(posedge clk) begin
    if (rd_en4)  rd_data4  <= mem[rd_addr4];
    if (rd_en16) rd_data16 <= mem[rd_addr16];
  end

  logic       o_rd_en, o_rdy, o_ss, o_busy, o_done;
  logic [7:0] o_addr, o_px;
  assign o_rd_en = sel ? rd_en16  : rd_en4;
  assign o_addr  = sel ? rd_addr16 : {4'b0000, rd_addr4};
  assign o_px    = sel ? px16     : px4;
  assign o_rdy   = sel ? px_rdy16 : px_rdy4;
  assign o_ss    = sel ? ss16     : ss4;
  assign o_busy  = sel ? busy16   : busy4;
  assign o_done  = sel ? done16   : done4;

  int n_checks = 0;
  int n_fail   = 0;

  int         px_cyc[$];
  logic [7:0] px_val[$];
  int         rd_cyc[$];
  int         rd_addr_q[$];
  bit         ss_log[$];
  bit         busy_log[$];
  int         done_cyc[$];
  int         hold_viol;
  int         hold_c5;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode: 0 plain, 1 hold 5 cycles after the 5th read, 2 random hold, 3 extra start, 4 reset mid-frame
  task automatic run(input int mode, input int budget);
    int c5;
    c5 = -1;
    px_cyc.delete(); px_val.delete(); rd_cyc.delete(); rd_addr_q.delete();
    ss_log.delete(); busy_log.delete(); done_cyc.delete();
    hold_viol = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      start = (k == 0) || (mode == 3 && k == 8);
      if (mode == 1)      hold = (c5 >= 0) && (k > c5) && (k <= c5 + 5);
      else if (mode == 2) hold = ($urandom_range(0, 3) == 0);
      else                hold = 1'b0;
      if (mode == 4 && k == 10) begin
        nreset = 1'b0;
        #1;
        check("reset_mid_frame_outputs",
              {o_rd_en, o_addr, o_px, o_rdy, o_ss, o_busy, o_done}, 0);
        break;
      end
      @(negedge clk);
      ss_log.push_back(o_ss);
      busy_log.push_back(o_busy);
      if (o_rd_en) begin
        rd_cyc.push_back(k);
        rd_addr_q.push_back(int'(o_addr));
        if (hold) hold_viol++;
      end
      if (o_rdy) begin
        px_cyc.push_back(k);
        px_val.push_back(o_px);
      end
      if (o_done) done_cyc.push_back(k);
      if (mode == 1 && c5 < 0 && rd_cyc.size() == 5) c5 = k;
      if (done_cyc.size() > 0 && k >= done_cyc[0] + 2) break;
    end
    start = 1'b0;
    hold  = 1'b0;
    hold_c5 = c5;
  endtask

  task automatic verify(input string tag, input int w, input int h);
    int exp_addr[$];
    int bad;
    int rises;
    for (int r = 0; r <= h - 3; r++)
      for (int c = 0; c < w; c++)
        for (int k = 0; k < 3; k++)
          exp_addr.push_back((r + k) * w + c);
    check({tag, "_px_count"}, px_val.size(), exp_addr.size());
    check({tag, "_rd_count"}, rd_addr_q.size(), exp_addr.size());
    bad = -1;
    for (int i = 0; i < px_val.size() && i < exp_addr.size(); i++)
      if (bad < 0 && px_val[i] !== mem[exp_addr[i]]) bad = i;
    check({tag, "_px_order_first_bad"}, bad, -1);
    bad = -1;
    for (int i = 0; i < rd_addr_q.size() && i < exp_addr.size(); i++)
      if (bad < 0 && rd_addr_q[i] != exp_addr[i]) bad = i;
    check({tag, "_addr_order_first_bad"}, bad, -1);
    bad = -1;
    for (int i = 0; i < px_cyc.size() && i < rd_cyc.size(); i++)
      if (bad < 0 && px_cyc[i] != rd_cyc[i] + 2) bad = i;
    check({tag, "_latency_first_bad"}, bad, -1);
    check({tag, "_done_count"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0 && px_cyc.size() > 0) begin
      check({tag, "_done_after_last_px"}, done_cyc[0], px_cyc[px_cyc.size() - 1] + 1);
      check({tag, "_busy_in_done_cycle"}, busy_log[done_cyc[0]], 0);
    end
    check({tag, "_reads_under_hold"}, hold_viol, 0);
    rises = 0;
    for (int i = 0; i < ss_log.size(); i++)
      if (ss_log[i] && (i == 0 || !ss_log[i - 1])) rises++;
    check({tag, "_strip_count"}, rises, h - 2);
  endtask

  initial begin
    int zeros;
    int late;
    nreset = 1'b0;
    start  = 1'b0;
    hold   = 1'b0;
    sel    = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_4x4", {rd_en4, rd_addr4, px4, px_rdy4, ss4, busy4, done4}, 0);
    check("reset_outputs_16x16", {rd_en16, rd_addr16, px16, px_rdy16, ss16, busy16, done16}, 0);
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // Plain 4x4 frame with memory[a]=a: order, latency and strip framing.
    run(0, 400);
    verify("plain4", 4, 4);
    check("busy_before_start", busy_log[0], 0);
    check("busy_after_start", busy_log[1], 1);
    if (rd_cyc.size() > 0) check("first_read_cycle", rd_cyc[0], 1);
    if (px_cyc.size() >= 13) begin
      check("ss_lead_first_px", ss_log[px_cyc[0] - 2], 1);
      check("ss_low_before_first", ss_log[px_cyc[0] - 3], 0);
      check("strip_duration", px_cyc[11] - rd_cyc[0], 13);
      check("strip_no_bubbles", px_cyc[11] - px_cyc[0], 11);
      check("ss_high_at_12th", ss_log[px_cyc[11]], 1);
      zeros = 0;
      for (int i = px_cyc[11] + 1; i < px_cyc[12]; i++) if (!ss_log[i]) zeros++;
      check("gap_low_cycles", zeros, 2);
      check("ss_lead_13th_px", ss_log[px_cyc[12] - 2], 1);
      check("ss_low_before_13th", ss_log[px_cyc[12] - 3], 0);
    end
    repeat (3) @(posedge clk);

    // Back-pressure: five held cycles right after the fifth read.
    run(1, 400);
    verify("hold4", 4, 4);
    if (hold_c5 >= 0 && rd_cyc.size() > 5) begin
      late = 0;
      zeros = 0;
      for (int i = 0; i < px_cyc.size(); i++) begin
        if (px_cyc[i] <= hold_c5 + 2) late++;
        if (px_cyc[i] > hold_c5 + 2 && px_cyc[i] <= hold_c5 + 5) zeros++;
      end
      check("hold_pulses_through_inflight", late, 5);
      check("hold_pulses_while_stalled", zeros, 0);
      check("hold_resume_cycle", rd_cyc[5], hold_c5 + 6);
      check("hold_resume_addr", rd_addr_q[5], 9);
    end
    repeat (3) @(posedge clk);

    // start_i pulsed mid-frame must not restart or queue a frame.
    run(3, 400);
    verify("restart4", 4, 4);
    check("busy_at_ignored_start", busy_log[8], 1);
    repeat (6) @(posedge clk);
    check("no_queued_frame", {busy4, rd_en4}, 0);

    // Reset mid-frame, then a clean frame from address 0.
    run(4, 400);
    check("no_done_on_abort", done_cyc.size(), 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    run(0, 400);
    verify("after_reset4", 4, 4);
    if (rd_addr_q.size() > 0) check("restart_first_addr", rd_addr_q[0], 0);
    repeat (3) @(posedge clk);

    // Random frame data and random back-pressure on both sizes.
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    run(2, 1000);
    verify("rand4", 4, 4);
    repeat (3) @(posedge clk);
    sel = 1'b1;
    repeat (2) @(posedge clk);
    run(0, 4000);
    verify("plain16", 16, 16);
    if (px_val.size() > 0) check("last_px_addr255", px_val[px_val.size() - 1], mem[255]);
    repeat (3) @(posedge clk);
    run(2, 5000);
    verify("rand16", 16, 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_px_feeder.md
# sobel_px_feeder

Frame-memory reader that produces the pixel stream a Sobel 3x3 window controller consumes. It reads a stored grayscale frame through a synchronous read port and emits pixels in column-major window order, strip by strip. The first window of each strip is sent as 9 pixels and each following window as 3 pixels, one new column. It sits between the grayscale frame buffer and the Sobel window controller and drives that controller's `start_sobel`, `px_rdy` and pixel inputs.

## Interface
- `PIXEL_WIDTH_OUT`, 8, pixel width; matches the Sobel input width.
- `IMG_WIDTH`, 16, frame width in pixels; must be at least 3.
- `IMG_HEIGHT`, 16, frame height in pixels; must be at least 3.
- `ADDR_BITS`, 8, read-address width; must satisfy 2^ADDR_BITS >= IMG_WIDTH*IMG_HEIGHT.
- `GAP_CYCLES`, 2, cycles `start_sobel_o` is held low between strips; must be at least 1.

- `clk_i` in 1: the single clock. All logic is on the rising edge.
- `nreset_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle frame start pulse. Ignored while `busy_o`=1.
- `hold_i` in 1: consumer back-pressure. While high, no new read is issued.
- `rd_en_o` out 1: memory read strobe.
- `rd_addr_o` out ADDR_BITS: read address, row*IMG_WIDTH+col.
- `rd_data_i` in PIXEL_WIDTH_OUT: read data, valid the cycle after `rd_en_o`.
- `px_o` out PIXEL_WIDTH_OUT: registered pixel to the Sobel controller.
- `px_rdy_o` out 1: one-cycle pulse, `px_o` valid.
- `start_sobel_o` out 1: strip-active level to the Sobel controller.
- `busy_o` out 1: frame in progress.
- `done_o` out 1: one-cycle pulse after the last pixel of the frame.

## Operation
- **Reset values.** All outputs are 0, the FSM is in IDLE and all counters are 0.
- **Frame structure.** The frame is processed as strips r = 0..IMG_HEIGHT-3. Strip r covers rows r, r+1 and r+2.
- **Per-strip order.** Columns c = 0..IMG_WIDTH-1 are sent in turn. Each column is sent as rows r, r+1, r+2, top to bottom.
  - The first 3 columns (9 pixels) form the first window.
  - Each later column (3 pixels) completes one further window.
  - Each strip produces 3*IMG_WIDTH pixels and IMG_WIDTH-2 windows.
- **FSM states.**
  - IDLE: `start_i` -> FILL. `busy_o` rises the cycle after the `start_i` pulse.
  - FILL: issues the 9 reads of columns 0..2 -> SLIDE.
  - SLIDE: issues 3 reads per column for columns 3..IMG_WIDTH-1. After the last read of the strip -> DRAIN.
  - DRAIN: waits until the last in-flight pixel has been emitted on `px_o`. Then -> GAP if more strips remain, else -> DONE.
  - GAP: `start_sobel_o`=0 for GAP_CYCLES cycles, then strip+1 -> FILL.
  - DONE: `done_o`=1 for one cycle, `busy_o`=0 -> IDLE.
- **Address generation.** Counters track column, row-in-column (0..2) and strip row base.
  - The row base advances by adding IMG_WIDTH; no multiplier is used.
  - `rd_addr_o` = row_base + row_in*IMG_WIDTH + col, built from adders only.
- **start_sobel_o.** Rises with the first `rd_en_o` of a strip. It stays high through the cycle of that strip's last `px_rdy_o` pulse, then falls.
- **hold_i.**
  - Stalls issue only. A read already issued still produces its `px_rdy_o` pulse.
  - Counters do not advance while held.
  - `start_sobel_o` stays high while held mid-strip.
- **Reset mid-frame.** Asynchronously returns to the reset values. No `done_o` pulse is produced.
- **start_i during a frame.** Has no effect and is not queued.

## Timing
- Read latency: `rd_en_o` in cycle t, `rd_data_i` valid in t+1, `px_o`/`px_rdy_o` in t+2.
- Throughput: 1 pixel per cycle when `hold_i`=0. There are no bubbles inside a strip.
- `start_sobel_o` leads the first `px_rdy_o` of a strip by 2 cycles.
- Strip duration from the first `rd_en_o` to the last `px_rdy_o` without hold: 3*IMG_WIDTH+1 cycles.
- `done_o` is asserted the cycle after the final `px_rdy_o`, and `busy_o` falls in that same cycle.
- `px_o` holds its last value between pulses.

## Test plan
- **Reset values.** Assert `nreset_i`=0 mid-run -> all outputs read 0 immediately and the FSM is in IDLE. Release and pulse `start_i` -> the frame restarts at address 0.
- **Pixel order, 4x4 frame.** IMG_WIDTH=4, IMG_HEIGHT=4, memory[a]=a, `hold_i`=0.
  - Strip 0 `px_o` sequence: 0,4,8,1,5,9,2,6,10,3,7,11.
  - Strip 1 `px_o` sequence: 4,8,12,5,9,13,6,10,14,7,11,15.
  - 24 pulses in total and exactly one `done_o`.
- **Strip gap.** Same setup -> `start_sobel_o` is low for exactly GAP_CYCLES=2 cycles between the 12th and 13th `px_rdy_o`. It is high 2 cycles before the 1st and the 13th pulse.
- **Back-pressure.** Assert `hold_i` for 5 cycles after the 5th read.
  - Exactly one further `px_rdy_o` arrives for the in-flight read, then none.
  - On release the sequence resumes at address 9.
  - Final order and count are unchanged.
- **Ignored start.** Pulse `start_i` while `busy_o`=1 -> no restart; pulse count stays 24.
- **Default size.** Default parameters, 16x16 frame -> 14 strips of 48 pixels (672 pulses). The last pixel is address 255. `done_o` occurs 1 cycle after the last pulse.
